// File: rtl/popcount_sched_pkg.sv
// Shared types and constants for the popcount neuron scheduler.
package popcount_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      POS,
      POS_W,
      NEG,
      NEG_W,
      RESP
   } state_t;

   localparam logic [1:0] TERN_POS  = 2'b01;
   localparam logic [1:0] TERN_NEG  = 2'b11;
   localparam logic [1:0] TERN_ZERO = 2'b00;

   localparam int PC_W  = 11;
   localparam int CNT_W = 4;
   localparam int TH_W  = 5;

endpackage

// File: rtl/popcount_neuron_sched_if.sv
// Requester and response bundle of the popcount neuron scheduler.
interface popcount_neuron_sched_if #(
   parameter  int N_REQ = 4,
   parameter  int PC_W  = popcount_sched_pkg::PC_W,
   parameter  int TH_W  = popcount_sched_pkg::TH_W,
   localparam int ID_W  = $clog2(N_REQ)
);
   logic [N_REQ-1:0]      req_valid;
   logic [N_REQ-1:0]      req_ready;
   logic [N_REQ*PC_W-1:0] req_pos;
   logic [N_REQ*PC_W-1:0] req_neg;
   logic signed [TH_W-1:0] cfg_th_hi;
   logic signed [TH_W-1:0] cfg_th_lo;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [ID_W-1:0]       rsp_id;
   logic signed [TH_W-1:0] rsp_sum;
   logic [1:0]            rsp_tern;

   modport master (
      output req_valid, req_pos, req_neg, cfg_th_hi, cfg_th_lo, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_tern
   );

   modport slave (
      input  req_valid, req_pos, req_neg, cfg_th_hi, cfg_th_lo, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_tern
   );
endinterface

// File: rtl/popcount_rr_arb.sv
// Round-robin arbiter: first requester at or after ptr, wrapping modulo N_REQ.
module popcount_rr_arb #(
   parameter  int N_REQ = 4,
   localparam int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  idx,
   output logic             any
);

   always_comb begin
      int j;
      j   = 0;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      // Walk from the farthest offset down so the nearest valid requester wins.
      for (int off = N_REQ - 1; off >= 0; off--) begin
         j = (int'(ptr) + off) % N_REQ;
         if (req[j]) begin
            gnt    = '0;
            gnt[j] = 1'b1;
            idx    = ID_W'(j);
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/popcount_neuron_sched.sv
// Time-shares one popcount datapath between ternary-neuron requesters.
// Define POPCOUNT_PIPE_EN when the shared popcount has a 1-cycle registered output.
//
// state | meaning
// IDLE  | arbitrate, accept and latch one job
// POS   | drive positive mask
// POS_W | hold positive mask while the registered popcount settles
// NEG   | drive negative mask
// NEG_W | hold negative mask while the registered popcount settles
// RESP  | present result until rsp_ready
module popcount_neuron_sched #(
   parameter  int N_REQ = 4,
   parameter  int PC_W  = popcount_sched_pkg::PC_W,
   parameter  int CNT_W = popcount_sched_pkg::CNT_W,
   parameter  int TH_W  = popcount_sched_pkg::TH_W,
   localparam int ID_W  = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   popcount_neuron_sched_if.slave  bus,
   output logic [PC_W-1:0]         pc_in,
   input  logic [CNT_W-1:0]        pc_out,
   output logic                    busy
);
   import popcount_sched_pkg::*;

`ifdef POPCOUNT_PIPE_EN
   localparam state_t POS_CAP = POS_W;
   localparam state_t NEG_CAP = NEG_W;
`else
   localparam state_t POS_CAP = POS;
   localparam state_t NEG_CAP = NEG;
`endif

   state_t                 state, state_nxt;
   logic [ID_W-1:0]        ptr, gnt_idx, id_q;
   logic [N_REQ-1:0]       gnt;
   logic                   any_req, accept;
   logic [PC_W-1:0]        pos_q, neg_q;
   logic signed [TH_W-1:0] th_hi_q, th_lo_q, sum;
   logic [CNT_W-1:0]       pos_cnt;
   logic [1:0]             tern;

   popcount_rr_arb #(.N_REQ(N_REQ)) u_arb (
      .req (bus.req_valid),
      .ptr (ptr),
      .gnt (gnt),
      .idx (gnt_idx),
      .any (any_req)
   );

   assign accept        = (state == IDLE) && any_req;
   assign bus.req_ready = accept ? gnt : '0;
   assign busy          = (state != IDLE);

   // Zero-extended counts cannot overflow TH_W = CNT_W+1 bits.
   assign sum = TH_W'({1'b0, pos_cnt}) - TH_W'({1'b0, pc_out});

   always_comb begin
      if (sum >= th_hi_q)      tern = TERN_POS;
      else if (sum <= th_lo_q) tern = TERN_NEG;
      else                     tern = TERN_ZERO;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pc_in     = '0;
      case (state)
         IDLE: if (any_req) state_nxt = POS;
         POS: begin
            pc_in = pos_q;
`ifdef POPCOUNT_PIPE_EN
            state_nxt = POS_W;
`else
            state_nxt = NEG;
`endif
         end
         POS_W: begin
            pc_in     = pos_q;
            state_nxt = NEG;
         end
         NEG: begin
            pc_in = neg_q;
`ifdef POPCOUNT_PIPE_EN
            state_nxt = NEG_W;
`else
            state_nxt = RESP;
`endif
         end
         NEG_W: begin
            pc_in     = neg_q;
            state_nxt = RESP;
         end
         RESP: if (bus.rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr           <= '0;
         id_q          <= '0;
         pos_q         <= '0;
         neg_q         <= '0;
         th_hi_q       <= '0;
         th_lo_q       <= '0;
         pos_cnt       <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_id    <= '0;
         bus.rsp_sum   <= '0;
         bus.rsp_tern  <= '0;
      end else begin
         if (accept) begin
            id_q    <= gnt_idx;
            pos_q   <= bus.req_pos[gnt_idx*PC_W +: PC_W];
            neg_q   <= bus.req_neg[gnt_idx*PC_W +: PC_W];
            th_hi_q <= bus.cfg_th_hi;
            th_lo_q <= bus.cfg_th_lo;
            ptr     <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
         end
         if (state == POS_CAP) pos_cnt <= pc_out;
         if (state == NEG_CAP) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_id    <= id_q;
            bus.rsp_sum   <= sum;
            bus.rsp_tern  <= tern;
         end else if (bus.rsp_valid && bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_popcount_neuron_sched.sv
// Self-checking bench for popcount_neuron_sched against a transaction-level model.
module tb_popcount_neuron_sched;

   localparam int N  = 4;
   localparam int PW = 11;
   localparam int CW = 4;
   localparam int TW = 5;
`ifdef POPCOUNT_PIPE_EN
   localparam int LAT    = 5;
   localparam int NEG_AT = 3;
`else
   localparam int LAT    = 3;
   localparam int NEG_AT = 2;
`endif

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic [PW-1:0] pc_in;
   logic [CW-1:0] pc_out;
   logic          busy;
   int cyc    = 0;
   int n_chk  = 0;
   int n_pass = 0;
   int mptr   = 0;

   popcount_neuron_sched_if #(.N_REQ(N), .PC_W(PW), .TH_W(TW)) bus ();

   popcount_neuron_sched #(.N_REQ(N), .PC_W(PW), .CNT_W(CW), .TH_W(TW)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus),
      .pc_in  (pc_in),
      .pc_out (pc_out),
      .busy   (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

`ifdef POPCOUNT_PIPE_EN
   always @(posedge clk) pc_out <= CW'($countones(pc_in));
`else
   always_comb pc_out = CW'($countones(pc_in));
`endif

   function automatic int exp_sum(input logic [PW-1:0] p, input logic [PW-1:0] n);
      return $countones(p) - $countones(n);
   endfunction

   function automatic logic [1:0] exp_tern(input int s, input int hi, input int lo);
      if (s >= hi) return 2'b01;
      if (s <= lo) return 2'b11;
      return 2'b00;
   endfunction

   function automatic int rr_pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++)
         if (v[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic job(input int g, input logic [PW-1:0] p, input logic [PW-1:0] n,
                      input logic signed [TW-1:0] hi, input logic signed [TW-1:0] lo,
                      input string tag);
      int t0, s, w;
      logic [1:0] te;
      s  = exp_sum(p, n);
      te = exp_tern(s, int'(hi), int'(lo));
      bus.req_valid          = '0;
      bus.req_valid[g]       = 1'b1;
      bus.req_pos[g*PW +: PW] = p;
      bus.req_neg[g*PW +: PW] = n;
      bus.cfg_th_hi          = hi;
      bus.cfg_th_lo          = lo;
      #1;
      chk({tag, "/req_ready"}, 32'(bus.req_ready), 32'(1 << g));
      t0   = cyc;
      mptr = (g + 1) % N;
      tick();
      bus.req_valid = '0;
      bus.cfg_th_hi = TW'($urandom);
      bus.cfg_th_lo = TW'($urandom);
      chk({tag, "/busy"}, 32'(busy), 32'(1));
      w = 0;
      while (!bus.rsp_valid && w < 20) begin
         tick();
         w++;
      end
      chk({tag, "/latency"}, 32'(cyc - t0), 32'(LAT));
      chk({tag, "/rsp_id"}, 32'(bus.rsp_id), 32'(g));
      chk({tag, "/rsp_sum"}, 32'(bus.rsp_sum), 32'(s));
      chk({tag, "/rsp_tern"}, 32'(bus.rsp_tern), 32'(te));
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      chk({tag, "/idle"}, 32'({bus.rsp_valid, busy}), 32'(0));
   endtask

   initial begin
      logic [PW-1:0] pm [N];
      logic [PW-1:0] nm [N];
      int expq[$];
      int acc, last, w, g, e, s, t0;
      logic [1:0] te;
      logic seen;

      bus.req_valid = '0;
      bus.req_pos   = '0;
      bus.req_neg   = '0;
      bus.cfg_th_hi = '0;
      bus.cfg_th_lo = '0;
      bus.rsp_ready = 1'b0;

      tick();
      chk("reset_outputs", 32'({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_sum,
                                bus.rsp_tern, busy, pc_in}), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      job(2, 11'h7FF, 11'h003, 5'sd4, -5'sd4, "single");
      job(1, 11'h001, 11'h0FF, 5'sd2, -5'sd3, "neg_tern");
      job(3, 11'h001, 11'h003, 5'sd2, -5'sd3, "zero_tern");
      job(0, 11'h00F, 11'h0F0, 5'sd0, 5'sd0, "overlap");

      // Backpressure: job 0 held in RESP while requester 1 waits.
      bus.req_valid          = 4'b0001;
      bus.req_pos[0 +: PW]   = 11'h1F0;
      bus.req_neg[0 +: PW]   = 11'h001;
      bus.req_pos[PW +: PW]  = 11'h003;
      bus.req_neg[PW +: PW]  = 11'h07F;
      bus.cfg_th_hi          = 5'sd3;
      bus.cfg_th_lo          = -5'sd3;
      s  = exp_sum(11'h1F0, 11'h001);
      te = exp_tern(s, 3, -3);
      #1;
      tick();
      bus.req_valid = 4'b0010;
      w = 0;
      while (!bus.rsp_valid && w < 20) begin
         tick();
         w++;
      end
      for (int k = 0; k < 10; k++) begin
         chk("bp_hold", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_tern,
                             bus.req_ready, pc_in}),
             32'({1'b1, 2'd0, 5'(s), te, 4'b0000, 11'h000}));
         tick();
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      chk("bp_next_grant", 32'(bus.req_ready), 32'(4'b0010));
      t0 = cyc;
      tick();
      bus.req_valid = '0;
      w = 0;
      while (!bus.rsp_valid && w < 20) begin
         tick();
         w++;
      end
      chk("bp_latency", 32'(cyc - t0), 32'(LAT));
      chk("bp_rsp", 32'({bus.rsp_id, bus.rsp_sum}), 32'({2'd1, 5'(exp_sum(11'h003, 11'h07F))}));
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;

      for (int k = 0; k < 8; k++) begin
         job(int'($urandom_range(0, N - 1)), PW'($urandom), PW'($urandom),
             TW'($urandom), TW'($urandom), "random");
      end

      // Async reset while the negative pass is on the popcount.
      bus.req_valid        = 4'b0001;
      bus.req_pos[0 +: PW] = 11'h0FF;
      bus.req_neg[0 +: PW] = 11'h00F;
      #1;
      tick();
      bus.req_valid = '0;
      repeat (NEG_AT - 1) tick();
      chk("neg_drive", 32'(pc_in), 32'(11'h00F));
      rst_n = 1'b0;
      #1;
      chk("async_reset", 32'({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_sum,
                              bus.rsp_tern, busy, pc_in}), 32'(0));
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      mptr  = 0;
      seen  = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         seen = seen | bus.rsp_valid;
      end
      chk("no_rsp_after_reset", 32'(seen), 32'(0));

      // All requesters valid, consumer always ready: strict round robin from 0.
      for (int k = 0; k < N; k++) begin
         pm[k] = PW'($urandom);
         nm[k] = PW'($urandom);
         bus.req_pos[k*PW +: PW] = pm[k];
         bus.req_neg[k*PW +: PW] = nm[k];
      end
      bus.cfg_th_hi = 5'sd3;
      bus.cfg_th_lo = -5'sd3;
      bus.rsp_ready = 1'b1;
      bus.req_valid = '1;
      acc  = 0;
      last = -1;
      w    = 0;
      #1;
      while ((acc < 5 || expq.size() > 0) && w < 80) begin
         if (bus.req_ready != '0) begin
            g = rr_pick(bus.req_valid, mptr);
            chk("rr_grant", 32'(bus.req_ready), 32'(1 << g));
            if (last >= 0) chk("rr_spacing", 32'(cyc - last), 32'(LAT + 1));
            last = cyc;
            mptr = (g + 1) % N;
            expq.push_back(g);
            acc++;
         end
         if (bus.rsp_valid) begin
            chk("rr_rsp_pending", 32'(expq.size() > 0), 32'(1));
            if (expq.size() > 0) begin
               e = expq.pop_front();
               chk("rr_rsp_id", 32'(bus.rsp_id), 32'(e));
               chk("rr_rsp_sum", 32'(bus.rsp_sum), 32'(exp_sum(pm[e], nm[e])));
            end
         end
         tick();
         if (acc >= 5) bus.req_valid = '0;
         w++;
      end
      chk("rr_complete", 32'({acc[7:0], 8'(expq.size())}), 32'({8'd5, 8'd0}));
      bus.rsp_ready = 1'b0;

      job(2, 11'h7FF, 11'h003, 5'sd4, -5'sd4, "single_again");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/popcount_neuron_sched.md
Name: popcount_neuron_sched

Overview:
- Sequencer and arbiter that time-shares one external 11-input approximate popcount datapath between N_REQ ternary-neuron requesters.
- Per job: two popcount passes, positive-weight mask then negative-weight mask. Computes signed sum = pos - neg and thresholds it to a ternary activation.
- Sits between neuron lanes and the shared popcount instance in the printed-NN accelerator.

Parameters:
- N_REQ, 4, number of requesters (>=2).
- PC_W, 11, popcount input width.
- CNT_W, 4, popcount output width.
- TH_W, 5, signed threshold/sum width; must be CNT_W+1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester job request.
- req_ready  out  N_REQ  one-hot accept pulse.
- req_pos  in  N_REQ*PC_W  positive masks; slice i = [i*PC_W +: PC_W].
- req_neg  in  N_REQ*PC_W  negative masks, same slicing.
- cfg_th_hi  in  TH_W  signed upper threshold, sampled at accept.
- cfg_th_lo  in  TH_W  signed lower threshold, sampled at accept.
- pc_in  out  PC_W  vector driven to the shared popcount.
- pc_out  in  CNT_W  popcount result (combinational path).
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  $clog2(N_REQ)  index of the served requester.
- rsp_sum  out  TH_W  signed pos - neg.
- rsp_tern  out  2  ternary result: 2'b01=+1, 2'b11=-1, 2'b00=0.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, RR pointer 0. Async assert aborts any job mid-flight; no partial response is ever issued.
- States: IDLE -> POS -> NEG -> RESP -> IDLE.
- IDLE:
  - If any req_valid is high, grant the first valid requester at or after the RR pointer, wrapping modulo N_REQ.
  - Assert req_ready[g] combinationally in that cycle.
  - Latch req_pos[g], req_neg[g], cfg_th_hi and cfg_th_lo. Set pointer = g+1 mod N_REQ, then go to POS.
  - req_ready is 0 in every other state.
- POS: pc_in = latched pos; register pc_out as pos_cnt; go to NEG.
- NEG: pc_in = latched neg; sum = {0,pos_cnt} - {0,pc_out}, computed in TH_W signed (range -15..+15, no overflow).
  - tern = +1 if sum >= th_hi, else -1 if sum <= th_lo, else 0. +1 wins when the thresholds overlap.
  - Register rsp_* and go to RESP.
- RESP: rsp_valid = 1, with rsp_* held stable until rsp_ready. On handshake clear rsp_valid and go to IDLE. The next grant occurs no earlier than the following cycle.
- pc_in = 0 in IDLE and RESP.
- Latency: accept at cycle T; rsp_valid at T+3 (T+5 with the optional feature). Throughput is 1 job per 4 cycles when rsp_ready is held high.
- Requesters must hold req_valid and masks until req_ready. Deasserting earlier is legal; that request is simply not granted.
- Simultaneous requests: strict RR, so no requester waits more than N_REQ-1 jobs.
- cfg_th_* changes after accept do not affect the running job.

Optional Feature:
- Macro: POPCOUNT_PIPE_EN.
- Defined: the shared popcount is assumed registered (1-cycle latency). Adds states POS_W and NEG_W after POS and NEG.
  - pc_in is held through the wait state.
  - pc_out is sampled in POS_W and NEG_W instead of POS and NEG.
  - Latency becomes T+5.
- Undefined: the combinational timing above applies.

Decomposition:
- Package popcount_sched_pkg holds:
  - state enum (IDLE, POS, POS_W, NEG, NEG_W, RESP);
  - ternary encodings TERN_POS=2'b01, TERN_NEG=2'b11, TERN_ZERO=2'b00;
  - default width constants PC_W=11, CNT_W=4, TH_W=5.
- One sub-module: popcount_rr_arb, a parameterised N_REQ round-robin arbiter. Inputs: request vector, pointer. Outputs: one-hot grant, grant index, any-valid.

Test Plan:
- Single job, req 2, pos=11'h7FF, neg=11'h003, th_hi=4, th_lo=-4, pc modelled exact -> req_ready[2] at T, rsp_valid at T+3, rsp_id=2, rsp_sum=9, rsp_tern=2'b01.
- All 4 requesters valid at once, rsp_ready tied 1 -> grant order 0,1,2,3,0; each rsp_id matches; accepts spaced exactly 4 cycles.
- pos=11'h001, neg=11'h0FF, th_hi=2, th_lo=-3 -> rsp_sum=-7, rsp_tern=2'b11. Repeat with neg=11'h003 -> rsp_sum=-1, rsp_tern=2'b00.
- Backpressure: rsp_ready=0 for 10 cycles with req 1 pending -> rsp_* stable, req_ready stays 0, pc_in=0. Release -> req 1 granted the cycle after the handshake.
- Overlapping thresholds th_hi=0, th_lo=0, sum=0 -> rsp_tern=2'b01.
- rst_n pulsed low during NEG -> all outputs 0 immediately, no rsp_valid afterwards. RR pointer restarts at 0; with POPCOUNT_PIPE_EN defined, re-run the first scenario and expect rsp_valid at T+5.
